// File: rtl/demux_deser4_if.sv
// rtl/demux_deser4_if.sv - bus bundle between the demux front end and the 4-channel deserializer
//
// Purpose: groups the per-bit strobe/select/data inputs, the flush and the
//          per-channel word handshake into one bundle.
// Signals:
//   bit_valid  - y[s] carries a data bit this cycle
//   s          - demux select, channel owning the current bit
//   y          - demux outputs, only y[s] is meaningful
//   clr        - synchronous flush of all channels
//   word_ack   - per-channel consumer acknowledge
//   word_out   - channel k word on [k*WIDTH +: WIDTH]
//   word_valid - per-channel word available
//   overrun    - per-channel sticky overrun
//   busy       - per-channel partial word in progress
// Modports: master drives bits/acks (producer + consumer side), slave is the deserializer.
interface demux_deser4_if #(
  parameter int WIDTH = 8
);
  logic                 bit_valid;
  logic [1:0]           s;
  logic [3:0]           y;
  logic                 clr;
  logic [3:0]           word_ack;
  logic [4*WIDTH-1:0]   word_out;
  logic [3:0]           word_valid;
  logic [3:0]           overrun;
  logic [3:0]           busy;

  modport master (
    output bit_valid, s, y, clr, word_ack,
    input  word_out, word_valid, overrun, busy
  );

  modport slave (
    input  bit_valid, s, y, clr, word_ack,
    output word_out, word_valid, overrun, busy
  );
endinterface

// File: rtl/demux_deser4.sv
// rtl/demux_deser4.sv - four independent MSB-first serial-to-parallel channels fed by a 1-to-4 demux
//
// Purpose: each channel k shifts in y[k] whenever bit_valid is set with s==k.
//          After WIDTH bits the word moves to a holding register, is offered
//          with word_valid[k] and retired by word_ack[k]. A word completing
//          while the previous one is still unacknowledged is dropped and
//          sets the sticky overrun[k].
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - demux_deser4_if.slave (bit_valid, s, y, clr, word_ack in;
//           word_out, word_valid, overrun, busy out)
module demux_deser4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_deser4_if.slave    bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q   [4];
  logic [WIDTH-1:0] sh_d   [4];
  logic [WIDTH-1:0] hold_q [4];
  logic [WIDTH-1:0] hold_d [4];
  logic [CW-1:0]    cnt_q  [4];
  logic [CW-1:0]    cnt_d  [4];
  logic [3:0]       v_q, v_d;
  logic [3:0]       o_q, o_d;
  logic [3:0]       done_c;

  always_comb begin
    done_c = '0;
    v_d    = v_q;
    o_d    = o_q;
    for (int k = 0; k < 4; k++) begin
      sh_d[k]   = sh_q[k];
      cnt_d[k]  = cnt_q[k];
      hold_d[k] = hold_q[k];
      if (bus.clr) begin
        sh_d[k]   = '0;
        cnt_d[k]  = '0;
        hold_d[k] = '0;
        v_d[k]    = 1'b0;
        o_d[k]    = 1'b0;
      end else begin
        // Only the selected channel samples; since s==k here, y[s] is y[k].
        if (bus.bit_valid && (bus.s == k[1:0])) begin
          sh_d[k] = {sh_q[k][WIDTH-2:0], bus.y[k]};
          if (cnt_q[k] == LAST) begin
            cnt_d[k]  = '0;
            done_c[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        if (done_c[k]) begin
          // An ack in the same cycle frees the holding slot for the new word.
          if (!v_q[k] || bus.word_ack[k]) begin
            hold_d[k] = sh_d[k];
            v_d[k]    = 1'b1;
          end else begin
            o_d[k] = 1'b1;
          end
        end else if (bus.word_ack[k]) begin
          v_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        sh_q[k]   <= '0;
        cnt_q[k]  <= '0;
        hold_q[k] <= '0;
      end
      v_q <= '0;
      o_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        sh_q[k]   <= sh_d[k];
        cnt_q[k]  <= cnt_d[k];
        hold_q[k] <= hold_d[k];
      end
      v_q <= v_d;
      o_q <= o_d;
    end
  end

  always_comb begin
    bus.word_out = '0;
    bus.busy     = '0;
    for (int k = 0; k < 4; k++) begin
      bus.word_out[k*WIDTH +: WIDTH] = hold_q[k];
      bus.busy[k]                    = (cnt_q[k] != '0);
    end
  end

  assign bus.word_valid = v_q;
  assign bus.overrun    = o_q;

endmodule

// File: tb/tb_demux_deser4.sv
// tb/tb_demux_deser4.sv - randomized and directed bench for demux_deser4 against a bit-list reference model
module tb_demux_deser4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_deser4_if #(.WIDTH(W)) bus_if ();

  demux_deser4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: bits received per channel, running word value, offered word
  int m_nb   [4];
  int m_acc  [4];
  int m_hold [4];
  bit m_v    [4];
  bit m_o    [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_nb[k] = 0; m_acc[k] = 0; m_hold[k] = 0; m_v[k] = 0; m_o[k] = 0;
    end
  endtask

  task automatic model_edge(input bit bv, input int ch, input bit b, input logic [3:0] ack, input bit clr);
    bit complete;
    if (clr) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 4; k++) begin
      complete = 0;
      if (bv && ch == k) begin
        m_acc[k] = (m_acc[k] * 2 + int'(b)) % (1 << W);
        m_nb[k]  = m_nb[k] + 1;
        if (m_nb[k] == W) begin
          m_nb[k]  = 0;
          complete = 1;
        end
      end
      if (complete) begin
        if (!m_v[k] || ack[k]) begin
          m_hold[k] = m_acc[k];
          m_v[k]    = 1;
        end else begin
          m_o[k] = 1;
        end
      end else if (ack[k]) begin
        m_v[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lane%0d", k), 32'(bus_if.word_out[k*W +: W]), 32'(m_hold[k]));
      chk($sformatf("valid%0d", k), 32'(bus_if.word_valid[k]), 32'(m_v[k]));
      chk($sformatf("ovr%0d", k), 32'(bus_if.overrun[k]), 32'(m_o[k]));
      chk($sformatf("busy%0d", k), 32'(bus_if.busy[k]), 32'(m_nb[k] != 0));
    end
  endtask

  // drive one cycle of inputs, clock it, update the model, compare
  task automatic step(input bit bv, input int ch, input bit b, input logic [3:0] ack, input bit clr);
    logic [3:0] yv;
    yv = 4'($urandom);
    yv[ch] = b;
    bus_if.bit_valid = bv;
    bus_if.s         = 2'(ch);
    bus_if.y         = yv;
    bus_if.word_ack  = ack;
    bus_if.clr       = clr;
    @(posedge clk);
    model_edge(bv, ch, b, ack, clr);
    #1;
    check_all();
    bus_if.bit_valid = 1'b0;
    bus_if.word_ack  = 4'b0;
    bus_if.clr       = 1'b0;
  endtask

  task automatic send_word(input int ch, input logic [7:0] wd, input logic [3:0] last_ack);
    for (int i = W - 1; i >= 0; i--)
      step(1'b1, ch, wd[i], (i == 0) ? last_ack : 4'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] c3;
    bus_if.bit_valid = 1'b0;
    bus_if.s         = 2'd0;
    bus_if.y         = 4'b0;
    bus_if.clr       = 1'b0;
    bus_if.word_ack  = 4'b0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    @(negedge clk);

    // 1. reset mid-word
    for (int i = 0; i < 5; i++) step(1'b1, 0, 1'($urandom), 4'b0, 1'b0);
    chk("busy_before_rst", 32'(bus_if.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", 32'(bus_if.busy), 32'h0);
    chk("rst_valid", 32'(bus_if.word_valid), 32'h0);
    chk("rst_word", bus_if.word_out, 32'h0);
    check_all();
    #2 rst_n = 1'b1;
    send_word(0, 8'h5A, 4'b0);
    chk("rst_one_word", 32'(bus_if.word_valid), 32'h1);
    chk("rst_word_val", 32'(bus_if.word_out[7:0]), 32'h5A);
    step(1'b0, 0, 1'b0, 4'b0001, 1'b0);

    // 2. single channel 2
    send_word(2, 8'hB2, 4'b0);
    chk("ch2_valid", 32'(bus_if.word_valid), 32'h4);
    chk("ch2_lane", 32'(bus_if.word_out[23:16]), 32'hB2);
    step(1'b0, 0, 1'b0, 4'b0100, 1'b0);
    chk("ch2_acked", 32'(bus_if.word_valid), 32'h0);

    // 3. interleave ch0 / ch3
    a5 = 8'hA5; c3 = 8'h3C;
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b1, 0, a5[i], 4'b0, 1'b0);
      step(1'b1, 3, c3[i], 4'b0, 1'b0);
    end
    chk("il_valid", 32'(bus_if.word_valid), 32'h9);
    chk("il_lane0", 32'(bus_if.word_out[7:0]), 32'hA5);
    chk("il_lane3", 32'(bus_if.word_out[31:24]), 32'h3C);
    chk("il_busy", 32'(bus_if.busy), 32'h0);
    step(1'b0, 0, 1'b0, 4'b1001, 1'b0);

    // 4. overrun on ch1
    send_word(1, 8'h11, 4'b0);
    send_word(1, 8'h22, 4'b0);
    chk("ovr_lane1", 32'(bus_if.word_out[15:8]), 32'h11);
    chk("ovr_flag", 32'(bus_if.overrun), 32'h2);
    step(1'b0, 0, 1'b0, 4'b0010, 1'b0);
    chk("ovr_sticky", 32'(bus_if.overrun), 32'h2);
    chk("ovr_acked", 32'(bus_if.word_valid[1]), 32'h0);
    step(1'b0, 0, 1'b0, 4'b0, 1'b1);
    chk("ovr_clr", 32'(bus_if.overrun), 32'h0);

    // 5. ack coincident with completion
    send_word(1, 8'h11, 4'b0);
    send_word(1, 8'h33, 4'b0010);
    chk("sim_lane1", 32'(bus_if.word_out[15:8]), 32'h33);
    chk("sim_valid", 32'(bus_if.word_valid[1]), 32'h1);
    chk("sim_ovr", 32'(bus_if.overrun[1]), 32'h0);

    // 6. clr beats bit_valid
    send_word(0, 8'hC7, 4'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2, 1'b1, 4'b0, 1'b0);
    chk("clr_pre_busy", 32'(bus_if.busy), 32'h4);
    step(1'b1, 2, 1'b1, 4'b0, 1'b1);
    chk("clr_valid", 32'(bus_if.word_valid), 32'h0);
    chk("clr_busy", 32'(bus_if.busy), 32'h0);
    chk("clr_ovr", 32'(bus_if.overrun), 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), 1'($urandom),
           4'($urandom) & 4'($urandom), ($urandom_range(0, 127) == 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/demux_deser4.md
Name: demux_deser4

Overview:
- Downstream stage of the 1-to-4 demux.
- Consumes the demux outputs y[3:0], its select s[1:0], and a per-bit strobe.
- Assembles four independent serial bit streams into WIDTH-bit parallel words, one channel per demux output.
- Each assembled word is held in a per-channel register and handed on with a valid/ack handshake; overruns are flagged per channel.

Parameters:
WIDTH, 8, bits per assembled word per channel (legal range 2..32)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
bit_valid  input  1  strobe: y[s] carries a valid data bit this cycle
s  input  2  demux select; channel the current bit belongs to
y  input  4  demux outputs; only y[s] is sampled
clr  input  1  synchronous flush of all channels
word_ack  input  4  per-channel consumer acknowledge
word_out  output  4*WIDTH  channel k word on bits [k*WIDTH +: WIDTH]
word_valid  output  4  per-channel word-available flag
overrun  output  4  per-channel sticky overrun flag
busy  output  4  per-channel partial word in progress (bit count != 0)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: asserting rst_n low immediately clears every shift register, bit counter, word_out, word_valid, overrun and busy to 0, regardless of clk. Reset mid-word discards the partial word.
- Per-channel state: shift register sh[k] (WIDTH bits), counter cnt[k] (clog2(WIDTH) bits), holding register hold[k], valid flag v[k], overrun flag o[k].
- Bit capture: on a rising edge with bit_valid=1 and clr=0, only channel k=s updates.
  - sh[k] <= {sh[k][WIDTH-2:0], y[s]}, MSB-first.
  - cnt[k] increments.
  - Other channels and y lines != s are ignored.
- Word completion: a bit captured while cnt[k]==WIDTH-1 completes the word.
  - cnt[k] wraps to 0.
  - The completed word, including the current bit, is offered to hold[k].
- Latency: a completing bit at edge N gives word_out lane k and word_valid[k]=1 visible after edge N, i.e. one cycle after the bit is presented.
- Handshake:
  - word_valid[k] stays high and word_out lane k stays stable until an edge where word_ack[k]=1. v[k] clears at that edge.
  - word_ack[k] while v[k]=0 is ignored.
- Completion with v[k]=0: load hold[k] and set v[k].
- Completion with v[k]=1 and word_ack[k]=1 in the same cycle: load the new word and keep v[k]=1. No overrun.
- Completion with v[k]=1 and word_ack[k]=0:
  - The new word is dropped and hold[k] is kept.
  - o[k] is set; it is sticky.
  - cnt[k] still wraps to 0.
- clr: synchronous, priority over bit_valid and word_ack. Clears sh, cnt, hold, v and o on all channels in one edge. This is the only way to clear overrun besides reset.
- busy[k] = (cnt[k] != 0), combinational from the registered counter.
- Channels are fully independent. Interleaved s values each advance only their own channel, so bit order within a channel is preserved across interleaving.
- No combinational path from inputs to word_out or word_valid; all outputs are registered except busy, which is decoded from registered state.

Test Plan:
All scenarios use WIDTH=8.
1. Reset mid-word: drive 5 bits on s=0, then pulse rst_n low between edges → all outputs 0 immediately; 8 further bits on s=0 yield exactly one word.
2. Single channel: s=2, bits 1,0,1,1,0,0,1,0 on consecutive cycles with bit_valid=1 → one cycle after the 8th bit, word_valid=4'b0100 and word_out[23:16]=8'hB2; other lanes stay 0. Ack at the next edge → word_valid=0.
3. Interleaved channels: alternate s=0 and s=3 each cycle, with channel 0 sending 8'hA5 and channel 3 sending 8'h3C → both valid; lane 0=8'hA5, lane 3=8'h3C; busy=0 afterward.
4. Overrun: complete 8'h11 on ch1, no ack, then complete 8'h22 on ch1 → word_out lane1 stays 8'h11 and overrun=4'b0010. A subsequent ack clears valid but overrun stays set until clr.
5. Simultaneous ack and completion: ch1 holds 8'h11; assert word_ack[1] on the same edge as the final bit of 8'h33 → lane1=8'h33, word_valid[1] stays 1, overrun[1]=0.
6. clr priority: assert clr together with bit_valid while ch2 is busy and ch0 is valid → next cycle all valid, busy and overrun are 0, and the strobed bit is discarded.
